instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction source directly upstream of simple_cpu: drives its 20-bit instruction input.
//   Holds a writable program store, sequences a program counter and issues one instruction per cycle.
//   Supports stall, jump and halt-word termination.
//   Emits NOP_WORD whenever no real instruction is issued, because the CPU executes every cycle.
// PARAMETERS
//   INSTR_WIDTH  20        instruction width, matches CPU instruction port
//   PC_BITS      5         program store depth = 2**PC_BITS (32 words)
//   NOP_WORD     20'h00000 word driven when instr_valid=0
//   HALT_WORD    20'hFFFFF terminating word; never issued to the CPU
// PORTS
//   clk          in   1            rising-edge clock
//   rst          in   1            asynchronous, active-high reset
//   prog_we      in   1            program store write enable (honoured only when busy=0)
//   prog_addr    in   PC_BITS      program store write address
//   prog_wdata   in   INSTR_WIDTH  program store write data
//   start        in   1            begin execution at address 0 (honoured only when busy=0)
//   stall        in   1            hold fetch; issue NOP this cycle
//   jump_en      in   1            fetch from jump_addr instead of pc
//   jump_addr    in   PC_BITS      jump target
//   instruction  out  INSTR_WIDTH  registered instruction to CPU
//   instr_valid  out  1            instruction is a real program word
//   pc           out  PC_BITS      address of next word to fetch
//   busy         out  1            1 in RUN
//   done         out  1            level; 1 in DONE until next start
// BEHAVIOUR
//   Reset (async, any state): instruction=NOP_WORD, instr_valid=0, pc=0, busy=0, done=0, state=IDLE.
//   Reset does not clear program store contents. A run in progress is abandoned.
//   States: IDLE, RUN, DONE. busy=(state==RUN). done=(state==DONE).
//   IDLE/DONE:
//   - prog_we writes mem[prog_addr]<=prog_wdata on the clock edge.
//   - start -> RUN, pc<=0, done<=0. If start and prog_we are both high, the write also completes.
//   RUN, stall=1: instruction<=NOP_WORD, instr_valid<=0, pc held. jump_en is ignored (dropped).
//   RUN, stall=0: fetch address A = jump_en ? jump_addr : pc, and W = mem[A].
//   - W==HALT_WORD: instruction<=NOP_WORD, instr_valid<=0, go to DONE, pc<=A.
//   - Otherwise: instruction<=W, instr_valid<=1, pc<=A+1.
//   - If A==2**PC_BITS-1 and W!=HALT_WORD: W is issued, then DONE next cycle with NOP_WORD and valid=0.
//     No wrap to 0; pc holds 2**PC_BITS-1.
//   Latency: start sampled at edge k; mem[0] appears on instruction after edge k+1, with valid=1.
//   In IDLE/DONE the outputs are instruction=NOP_WORD and instr_valid=0.
//   prog_we and start are ignored in RUN; the store is unchanged.
//   Store reads are combinational from the register array; the output is registered.
// TESTING
//   1. Load mem[0..3]=0x12345,0x0ABCD,0x00F0F,0xFFFFF; pulse start.
//      -> valid words 0x12345,0x0ABCD,0x00F0F on 3 consecutive cycles, then NOP/valid=0, done=1, pc=3.
//   2. Same program; stall=1 on the 2nd RUN cycle.
//      -> sequence 0x12345, NOP(valid=0), 0x0ABCD, 0x00F0F, then done. pc holds 1 during stall.
//   3. mem[5]=0x00555, mem[6]=HALT; jump_en=1, jump_addr=5 on the first RUN cycle.
//      -> instruction=0x00555, valid=1, pc=6, then done=1.
//   4. stall=1 and jump_en=1 together -> NOP issued, jump dropped, next fetch from unchanged pc.
//   5. prog_we to mem[2]=0x11111 while busy=1 -> on the rerun, mem[2] still reads the old value.
//      start while busy=1 -> no effect.
//   6. Assert rst mid-run, asynchronously between edges.
//      -> outputs are immediately NOP/valid=0/pc=0/busy=0.
//      A restart re-issues the program from mem[0] with the store intact.
//   7. All 32 words non-halt -> 32 valid issues, pc=31, then DONE with no wrap.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction source for simple_cpu. It holds a writable program store,
// steps a program counter and issues one registered instruction per cycle.
// It supports stall, jump and a halt word that ends the run. When no real
// instruction goes out it drives NOP_WORD, because the CPU executes every
// cycle.

module instr_fetch_unit #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 5,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_wdata,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic [PC_BITS-1:0]     jump_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 1 << PC_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Set after the top word has been issued. The run then ends on the next
  // edge, so the counter never wraps back to address 0.
  logic end_pending;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic [PC_BITS-1:0]     fetch_addr;
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic                   fetch_is_halt;
  logic                   fetch_is_last;

  // A jump overrides the counter for this fetch only. The read is
  // combinational, so the word is registered on the same edge.
  assign fetch_addr    = jump_en ? jump_addr : pc;
  assign fetch_word    = mem[fetch_addr];
  assign fetch_is_halt = (fetch_word == HALT_WORD);
  assign fetch_is_last = (fetch_addr == {PC_BITS{1'b1}});

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Program store writes. The store is locked while a run is in progress.
  // It has no reset, so a program survives a reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state != RUN)) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // Fetch sequencer: run control, program counter and the registered
  // instruction stream to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      end_pending <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          instruction <= NOP_WORD;
          instr_valid <= 1'b0;
          end_pending <= 1'b0;
          if (start) begin
            state <= RUN;
            pc    <= '0;
          end
        end

        RUN: begin
          if (end_pending) begin
            state       <= DONE;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            end_pending <= 1'b0;
          end else if (stall) begin
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
          end else if (fetch_is_halt) begin
            state       <= DONE;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            pc          <= fetch_addr;
          end else begin
            instruction <= fetch_word;
            instr_valid <= 1'b1;
            if (fetch_is_last) begin
              pc          <= fetch_addr;
              end_pending <= 1'b1;
            end else begin
              pc <= fetch_addr + PC_BITS'(1);
            end
          end
        end

        default: begin
          state       <= IDLE;
          instruction <= NOP_WORD;
          instr_valid <= 1'b0;
          end_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Scoreboard bench for instr_fetch_unit. Each RUN cycle's stimulus pushes
// the expected output. That entry is popped and compared once the DUT has
// produced the output.

module tb_instr_fetch_unit;

  localparam logic [19:0] NOP  = 20'h00000;
  localparam logic [19:0] HALT = 20'hFFFFF;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [19:0] prog_wdata;
  logic        start;
  logic        stall;
  logic        jump_en;
  logic [4:0]  jump_addr;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  typedef struct {
    logic [19:0] instr;
    logic        valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t  sb_q[$];
  int    checks   = 0;
  int    failures = 0;
  string cur_test = "reset";

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .start       (start),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: %s observed=%0h expected=%0h", cur_test, tag,
               observed, expected);
    end
  endtask

  // Check every output against one expectation entry
  task automatic checkAll(input exp_t e);
    checkOutput("instruction", 32'(instruction), 32'(e.instr));
    checkOutput("instr_valid", 32'(instr_valid), 32'(e.valid));
    checkOutput("pc",          32'(pc),          32'(e.pc));
    checkOutput("busy",        32'(busy),        32'(e.busy));
    checkOutput("done",        32'(done),        32'(e.done));
  endtask

  // Drive one cycle of run controls and queue the expected output. After
  // the edge, pop the entry and compare. The task is called at a negedge
  // and returns at the next negedge.
  task automatic applyStimulus(input logic s, input logic je, input logic [4:0] ja,
                               input logic [19:0] ei, input logic ev,
                               input logic [4:0] ep, input logic eb, input logic ed);
    exp_t e;
    stall     = s;
    jump_en   = je;
    jump_addr = ja;
    sb_q.push_back('{instr: ei, valid: ev, pc: ep, busy: eb, done: ed});
    @(posedge clk);
    @(negedge clk);
    stall   = 1'b0;
    jump_en = 1'b0;
    prog_we = 1'b0;
    start   = 1'b0;
    e = sb_q.pop_front();
    checkAll(e);
  endtask

  // Write one store word through the programming port
  task automatic loadWord(input logic [4:0] a, input logic [19:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Pulse start. The cycle after the start edge is RUN with no real word yet.
  task automatic startRun();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkAll('{instr: NOP, valid: 1'b0, pc: 5'd0, busy: 1'b1, done: 1'b0});
  endtask

  // The basic four-word program, ending in the halt at address 3
  task automatic runBasic();
    startRun();
    applyStimulus(0, 0, 0, 20'h12345, 1, 5'd1, 1, 0);
    applyStimulus(0, 0, 0, 20'h0ABCD, 1, 5'd2, 1, 0);
    applyStimulus(0, 0, 0, 20'h00F0F, 1, 5'd3, 1, 0);
    applyStimulus(0, 0, 0, NOP,       0, 5'd3, 0, 1);
  endtask

  initial begin
    rst        = 1'b1;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    start      = 1'b0;
    stall      = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = '0;

    repeat (3) @(negedge clk);
    checkAll('{instr: NOP, valid: 1'b0, pc: 5'd0, busy: 1'b0, done: 1'b0});
    rst = 1'b0;
    @(negedge clk);

    // Load the base program. Outputs stay idle during loading.
    cur_test = "load";
    loadWord(5'd0, 20'h12345);
    loadWord(5'd1, 20'h0ABCD);
    loadWord(5'd2, 20'h00F0F);
    loadWord(5'd3, HALT);
    loadWord(5'd5, 20'h00555);
    loadWord(5'd6, HALT);
    checkAll('{instr: NOP, valid: 1'b0, pc: 5'd0, busy: 1'b0, done: 1'b0});

    // Straight run to the halt word, then DONE holds
    cur_test = "t1_basic";
    runBasic();
    applyStimulus(0, 0, 0, NOP, 0, 5'd3, 0, 1);

    // Stall on the second RUN cycle inserts one NOP and holds pc
    cur_test = "t2_stall";
    startRun();
    applyStimulus(0, 0, 0, 20'h12345, 1, 5'd1, 1, 0);
    applyStimulus(1, 0, 0, NOP,       0, 5'd1, 1, 0);
    applyStimulus(0, 0, 0, 20'h0ABCD, 1, 5'd2, 1, 0);
    applyStimulus(0, 0, 0, 20'h00F0F, 1, 5'd3, 1, 0);
    applyStimulus(0, 0, 0, NOP,       0, 5'd3, 0, 1);

    // Jump on the first RUN cycle to 5, whose successor is a halt
    cur_test = "t3_jump";
    startRun();
    applyStimulus(0, 1, 5'd5, 20'h00555, 1, 5'd6, 1, 0);
    applyStimulus(0, 0, 0,    NOP,       0, 5'd6, 0, 1);

    // Stall with jump: the jump is dropped
    cur_test = "t4_stall_jump";
    startRun();
    applyStimulus(0, 0, 0,    20'h12345, 1, 5'd1, 1, 0);
    applyStimulus(1, 1, 5'd5, NOP,       0, 5'd1, 1, 0);
    applyStimulus(0, 0, 0,    20'h0ABCD, 1, 5'd2, 1, 0);
    applyStimulus(0, 0, 0,    20'h00F0F, 1, 5'd3, 1, 0);
    applyStimulus(0, 0, 0,    NOP,       0, 5'd3, 0, 1);

    // Write and start while busy are both ignored
    cur_test = "t5_busy_ignore";
    startRun();
    prog_we    = 1'b1;
    prog_addr  = 5'd2;
    prog_wdata = 20'h11111;
    start      = 1'b1;
    applyStimulus(0, 0, 0, 20'h12345, 1, 5'd1, 1, 0);
    applyStimulus(0, 0, 0, 20'h0ABCD, 1, 5'd2, 1, 0);
    applyStimulus(0, 0, 0, 20'h00F0F, 1, 5'd3, 1, 0);
    applyStimulus(0, 0, 0, NOP,       0, 5'd3, 0, 1);
    cur_test = "t5_rerun";
    runBasic();

    // Asynchronous reset mid-run, then a restart with the store intact
    cur_test = "t6_async_rst";
    startRun();
    applyStimulus(0, 0, 0, 20'h12345, 1, 5'd1, 1, 0);
    #2 rst = 1'b1;
    #1;
    checkAll('{instr: NOP, valid: 1'b0, pc: 5'd0, busy: 1'b0, done: 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cur_test = "t6_restart";
    runBasic();

    // Full store of non-halt words: 32 issues, pc holds at 31, no wrap
    cur_test = "t7_full";
    for (int i = 0; i < 32; i++) begin
      loadWord(5'(i), 20'h10000 + 20'(i));
    end
    startRun();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 20'h10000 + 20'(i), 1,
                    (i == 31) ? 5'd31 : 5'(i + 1), 1, 0);
    end
    applyStimulus(0, 0, 0, NOP, 0, 5'd31, 0, 1);
    applyStimulus(0, 0, 0, NOP, 0, 5'd31, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
